ezm_cpu_gen2: RTL
=================

Name: ezm_cpu_gen2

Overview:
- Second-generation accumulator CPU for the pin-limited tile wrapper: 6-bit instruction bus in, DW-bit status bus out.
- Keeps the two-phase FETCH/EXEC model: opcode class sampled in FETCH, operand field sampled in EXEC.
- Adds parametrised data/PC width and register-bank depth, a carry flag, shift/subtract operations, and a sticky HALT state.
- Sits directly under the tile top module; clk, rst and the instruction bus come straight from io_in.

Parameters:
- DW, 8, accumulator/register/output width; legal range 5..16.
- NREG, 8, register-bank depth; legal values 2, 4, 8.
- PCW, 8, program-counter width; must satisfy PCW <= DW.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_i  input  6  instruction/operand bus.
- out_o  output  DW  pc (zero-extended to DW) in FETCH; accumulator c in EXEC and HALT.
- exec_o  output  1  1 when state is EXEC or HALT.
- carry_o  output  1  carry flag.
- halt_o  output  1  1 in HALT.

Behaviour:
- States: FETCH(0), EXEC(1), HALT(2); encoding is defined in the package.
- Reset (clk edge with rst=1), regardless of state: c=0, pc=0, carry=0, all bank[] entries=0, op=NOP, state=FETCH. Outputs after reset: out_o=0, exec_o=0, carry_o=0, halt_o=0.
- FETCH, one cycle:
  - pc <= pc+1, wrapping modulo 2^PCW.
  - Latch op from in_i; priority matching:
    - 1xxxxx LOADI
    - 011rrr BGT
    - 001rrr STORE
    - 010rrr ADD
    - 000001 NOT
    - 000010 SHL
    - 000011 SHR
    - 000100 SUB
    - 000111 HALT
    - anything else NOP.
  - Next state = EXEC.
- EXEC, one cycle. Register index r = in_i[log2(NREG)-1:0] sampled this cycle; higher bits are ignored (mod NREG).
  - LOADI: c <= in_i[4:0] sign-extended to DW; carry unchanged.
  - BGT: if bank[r] > c (unsigned), pc <= pc - c[PCW-1:0] mod 2^PCW, using the already-incremented pc. Otherwise no change.
  - STORE: bank[r] <= c.
  - ADD: {carry,c} <= c + bank[r], computed at DW+1 bits.
  - SUB: c <= c - bank[r]; carry <= 1 when a borrow occurred (c < bank[r]).
  - NOT: c <= ~c; carry unchanged.
  - SHL: carry <= c[DW-1]; c <= c<<1.
  - SHR: carry <= c[0]; c <= c>>1 (logical).
  - HALT: next state = HALT. For every other op, next state = FETCH.
  - NOP: no state change other than the return to FETCH.
- HALT: all registers frozen; out_o=c, halt_o=1, exec_o=1; only rst exits.
- Instruction latency: 2 cycles. Results are visible on out_o in the EXEC cycle following the edge that executes them, i.e. while the next FETCH presents pc. A bench reads c by observing out_o during the next EXEC, or via HALT.
- The register bank is read asynchronously and written on the clock edge. A STORE followed by an ADD on the same r sees the new value.
- All outputs are registered-state derived; no combinational path from in_i to out_o.

Decomposition:
- Shared package ezm_pkg holds:
  - the state enum;
  - the op enum (NOP, LOADI, BGT, STORE, ADD, SUB, NOT, SHL, SHR, HALT);
  - the opcode pattern constants for the 000xxx sub-opcodes.
- One natural sub-module, ezm_alu: combinational; inputs op, c, bank operand, carry; outputs next c and next carry. The FSM, pc and bank stay in ezm_cpu_gen2.

Test Plan:
- Reset then idle NOPs (in_i=000000) for 4 cycles -> out_o alternates pc 1,c 0,pc 2,c 0; carry_o=0.
- LOADI 0x1F (in_i=111111) -> c=0xFF at DW=8; then STORE r3, LOADI 1, ADD r3 -> c=0x00, carry_o=1.
- LOADI 3, STORE r0, LOADI 5, SUB r0 -> c=2, carry=0; then LOADI 3... SUB r1 with r1=5 -> c=0xFE, carry=1.
- LOADI 0x10 (=0xF0 sign-ext), SHL -> c=0xE0, carry=1; SHR -> c=0x70, carry=0.
- LOADI 2, STORE r1, LOADI 1, BGT r1 issued at pc=6 -> pc becomes 7-1=6 and the loop repeats. BGT r1 with c=3 -> no branch.
- HALT (000111) then random in_i for 10 cycles -> halt_o=1, out_o frozen at c; assert rst mid-HALT -> next cycle all outputs 0, state FETCH.

Source files
------------

// File: rtl/ezm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ezm_pkg
// Description : Shared types and opcode constants for the ezm_cpu_gen2
//               accumulator CPU (state enum, op enum, opcode decoder).
// Revision    : 1.0 - initial release
// ============================================================================
package ezm_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_LOADI = 4'd1,
        OP_BGT   = 4'd2,
        OP_STORE = 4'd3,
        OP_ADD   = 4'd4,
        OP_SUB   = 4'd5,
        OP_NOT   = 4'd6,
        OP_SHL   = 4'd7,
        OP_SHR   = 4'd8,
        OP_HALT  = 4'd9
    } op_t;

    // Class prefixes for the register-addressed opcodes (bits [5:3])
    localparam logic [2:0] c_cls_store = 3'b001;
    localparam logic [2:0] c_cls_add   = 3'b010;
    localparam logic [2:0] c_cls_bgt   = 3'b011;

    // Full patterns for the 000xxx sub-opcodes
    localparam logic [5:0] c_opc_not  = 6'b000001;
    localparam logic [5:0] c_opc_shl  = 6'b000010;
    localparam logic [5:0] c_opc_shr  = 6'b000011;
    localparam logic [5:0] c_opc_sub  = 6'b000100;
    localparam logic [5:0] c_opc_halt = 6'b000111;

    // Priority decode of the instruction bus sampled in FETCH
    function automatic op_t decode_op(input logic [5:0] ins);
        op_t op;
        op = OP_NOP;
        if (ins[5]) begin
            op = OP_LOADI;
        end else if (ins[5:3] == c_cls_bgt) begin
            op = OP_BGT;
        end else if (ins[5:3] == c_cls_store) begin
            op = OP_STORE;
        end else if (ins[5:3] == c_cls_add) begin
            op = OP_ADD;
        end else begin
            case (ins)
                c_opc_not:  op = OP_NOT;
                c_opc_shl:  op = OP_SHL;
                c_opc_shr:  op = OP_SHR;
                c_opc_sub:  op = OP_SUB;
                c_opc_halt: op = OP_HALT;
                default:    op = OP_NOP;
            endcase
        end
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ezm_alu.sv
`default_nettype none
// ============================================================================
// Module      : ezm_alu
// Description : Combinational accumulator ALU: computes next accumulator and
//               carry from the latched op, accumulator, bank operand and the
//               5-bit immediate.
// Revision    : 1.0 - initial release
// ============================================================================
module ezm_alu
    import ezm_pkg::*;
#(
    parameter int DW = 8
) (
    input  op_t           i_op,
    input  logic [DW-1:0] i_c,
    input  logic [DW-1:0] i_operand,
    input  logic [4:0]    i_imm,
    input  logic          i_carry,
    output logic [DW-1:0] o_c_nxt,
    output logic          o_carry_nxt
);

    logic [DW:0]   w_sum;
    logic [DW:0]   w_diff;
    logic [DW-1:0] w_imm_ext;

    // Extra top bit carries out of the add and flags a borrow on the subtract
    assign w_sum     = {1'b0, i_c} + {1'b0, i_operand};
    assign w_diff    = {1'b0, i_c} - {1'b0, i_operand};
    assign w_imm_ext = DW'($signed(i_imm));

    // Result select; ops that do not touch c/carry hold their current values
    always_comb begin
        o_c_nxt     = i_c;
        o_carry_nxt = i_carry;
        case (i_op)
            OP_LOADI: o_c_nxt = w_imm_ext;
            OP_ADD: begin
                o_c_nxt     = w_sum[DW-1:0];
                o_carry_nxt = w_sum[DW];
            end
            OP_SUB: begin
                o_c_nxt     = w_diff[DW-1:0];
                o_carry_nxt = w_diff[DW];
            end
            OP_NOT: o_c_nxt = ~i_c;
            OP_SHL: begin
                o_c_nxt     = {i_c[DW-2:0], 1'b0};
                o_carry_nxt = i_c[DW-1];
            end
            OP_SHR: begin
                o_c_nxt     = {1'b0, i_c[DW-1:1]};
                o_carry_nxt = i_c[0];
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ezm_cpu_gen2.sv
`default_nettype none
// ============================================================================
// Module      : ezm_cpu_gen2
// Description : Two-phase (FETCH/EXEC) accumulator CPU with register bank,
//               carry flag, relative backward branch and sticky HALT.
// Revision    : 1.0 - initial release
// ============================================================================
module ezm_cpu_gen2
    import ezm_pkg::*;
#(
    parameter int DW   = 8,
    parameter int NREG = 8,
    parameter int PCW  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [5:0]    in_i,
    output logic [DW-1:0] out_o,
    output logic          exec_o,
    output logic          carry_o,
    output logic          halt_o
);

    localparam int c_rw = $clog2(NREG);

    state_t          r_state;
    state_t          w_state_nxt;
    op_t             r_op;
    logic [DW-1:0]   r_c;
    logic            r_carry;
    logic [PCW-1:0]  r_pc;
    logic [DW-1:0]   r_bank [NREG];

    logic [c_rw-1:0] w_idx;
    logic [DW-1:0]   w_operand;
    logic [DW-1:0]   w_c_nxt;
    logic            w_carry_nxt;
    logic            w_branch;

    // Register index comes from the operand cycle; upper bits are don't-care
    assign w_idx     = in_i[c_rw-1:0];
    assign w_operand = r_bank[w_idx];
    assign w_branch  = (r_op == OP_BGT) && (w_operand > r_c);

    ezm_alu #(
        .DW (DW)
    ) u_alu (
        .i_op        (r_op),
        .i_c         (r_c),
        .i_operand   (w_operand),
        .i_imm       (in_i[4:0]),
        .i_carry     (r_carry),
        .o_c_nxt     (w_c_nxt),
        .o_carry_nxt (w_carry_nxt)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: FETCH->EXEC->FETCH, except a HALT op parks in HALT
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FETCH: w_state_nxt = ST_EXEC;
            ST_EXEC:  w_state_nxt = (r_op == OP_HALT) ? ST_HALT : ST_FETCH;
            ST_HALT:  w_state_nxt = ST_HALT;
            default:  w_state_nxt = ST_FETCH;
        endcase
    end

    // Datapath: pc/op update in FETCH, accumulator/carry/branch in EXEC
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c     <= '0;
            r_carry <= 1'b0;
            r_pc    <= '0;
            r_op    <= OP_NOP;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    r_pc <= r_pc + 1'b1;
                    r_op <= decode_op(in_i);
                end
                ST_EXEC: begin
                    r_c     <= w_c_nxt;
                    r_carry <= w_carry_nxt;
                    // Branch is relative to the already-incremented pc
                    if (w_branch) begin
                        r_pc <= r_pc - r_c[PCW-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Register bank: asynchronous read above, write on STORE in EXEC
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_bank[i] <= '0;
            end
        end else if ((r_state == ST_EXEC) && (r_op == OP_STORE)) begin
            r_bank[w_idx] <= r_c;
        end
    end

    // Outputs derived only from registered state
    assign out_o   = (r_state == ST_FETCH) ? DW'(r_pc) : r_c;
    assign exec_o  = (r_state != ST_FETCH);
    assign halt_o  = (r_state == ST_HALT);
    assign carry_o = r_carry;

endmodule
`default_nettype wire
